// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_A   = 7;
    localparam int SAMPLE_B   = 8;
    localparam int SAMPLE_C   = 9;

    // Clocks per oversample tick, floored and never below one.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        int div;
        div = clk_freq / (baud_rate * OVERSAMPLE);
        if (div < 1) begin
            div = 1;
        end
        return div;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; a push while full (and not popping)
// is dropped and flagged with a one-cycle overrun pulse.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign overrun = overrun_q;

    always_comb begin
        do_pop    = pop & ~empty;
        // Full with a simultaneous pop still has room for the new word.
        do_push   = push & (~full | do_pop);
        overrun_d = push & full & ~do_pop;
        wr_ptr_d  = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d   = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// 16x oversampled UART receiver with majority vote and FWFT receive FIFO.
// Parity bit support is added by defining UART_RX_PARITY_EN.
//
// state     | meaning
// ST_IDLE   | line idle, waiting for a synchronised falling edge
// ST_START  | validating the start bit at mid-bit
// ST_DATA   | shifting in data bits, LSB first
// ST_PARITY | sampling and checking the parity bit
// ST_STOP   | checking stop bits, push or report error
// ST_BREAK  | line held low after a framing error, wait for idle
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 115200,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
`ifdef UART_RX_PARITY_EN
    parameter int FIFO_DEPTH     = 16,
    parameter bit PARITY_ODD     = 1'b0
`else
    parameter int FIFO_DEPTH     = 16
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rxd,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int DIV = calc_div(clk_freq, uart_baud_rate);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] DIV_M1   = TW'(DIV - 1);
    localparam logic [TW-1:0] TICK_ONE = TW'(1);
    localparam logic [SW-1:0] S_A      = SW'(SAMPLE_A);
    localparam logic [SW-1:0] S_B      = SW'(SAMPLE_B);
    localparam logic [SW-1:0] S_C      = SW'(SAMPLE_C);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_ONE    = SW'(1);
    localparam logic [3:0]    DB_M1    = 4'(DATA_BITS - 1);
    localparam logic [3:0]    SB_M1    = 4'(STOP_BITS - 1);

    rx_state_e            state_q, state_d;
    logic                 rxd_sync1_q, rxd_sync2_q, rxd_prev_q;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]        sample_cnt_q, sample_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           samp_q, samp_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 par_bad_q, par_bad_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 rxd_s, tick, vote_tick, bit_end, vote, stop_bad_now;
    logic                 word_push, fifo_empty;

    assign rxd_s      = rxd_sync2_q;
    assign tick       = (state_q != ST_IDLE) && (tick_cnt_q == '0);
    assign vote_tick  = tick && (sample_cnt_q == S_C);
    assign bit_end    = tick && (sample_cnt_q == S_LAST);
    // Samples 7 and 8 are held; sample 9 is the live line at the vote tick.
    assign vote       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);
    assign stop_bad_now = stop_bad_q | ~vote;

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        samp_d       = samp_q;
        stop_bad_d   = stop_bad_q;
        par_bad_d    = par_bad_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        word_push    = 1'b0;

        if (state_q != ST_IDLE) begin
            tick_cnt_d = tick ? DIV_M1 : tick_cnt_q - TICK_ONE;
            if (tick) begin
                sample_cnt_d = sample_cnt_q + S_ONE;
                if (sample_cnt_q == S_A) samp_d[0] = rxd_s;
                if (sample_cnt_q == S_B) samp_d[1] = rxd_s;
            end
        end

        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = DIV_M1;
                if (rxd_prev_q && !rxd_s) begin
                    state_d      = ST_START;
                    sample_cnt_d = '0;
                    stop_bad_d   = 1'b0;
                    par_bad_d    = 1'b0;
                end
            end
            ST_START: begin
                if (vote_tick && vote) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (vote_tick) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == DB_M1) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (vote_tick) begin
                    par_bad_d = vote ^ (^shift_q) ^ PARITY_ODD;
                end
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (vote_tick) begin
                    stop_bad_d = stop_bad_now;
                    if (bit_cnt_q == SB_M1) begin
                        if (stop_bad_now) begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end else if (par_bad_q) begin
                            parity_err_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            word_push = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                end
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            ST_BREAK: begin
                if (rxd_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_sync1_q  <= 1'b1;
            rxd_sync2_q  <= 1'b1;
            rxd_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            tick_cnt_q   <= DIV_M1;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            samp_q       <= '0;
            stop_bad_q   <= 1'b0;
            par_bad_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rxd_sync1_q  <= uart_rxd;
            rxd_sync2_q  <= rxd_sync1_q;
            rxd_prev_q   <= rxd_sync2_q;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            stop_bad_q   <= stop_bad_d;
            par_bad_q    <= par_bad_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign rx_valid   = ~fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (word_push),
        .push_data (shift_q),
        .pop       (rx_ready),
        .head      (rx_data),
        .full      (),
        .empty     (fifo_empty),
        .count     (rx_count),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param at DIV=2 (32 clocks per bit), FIFO depth 4.
module tb_uart_rx_param;

    localparam int DEPTH    = 4;
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int BIT_CLKS = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          uart_rxd = 1'b1;
    logic          rx_ready = 1'b0;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [CW-1:0] rx_count;
    logic          frame_err, parity_err, overrun;

    int checks = 0;
    int errors = 0;
    int n_ferr = 0, n_perr = 0, n_ovr = 0;
    int exp_ferr = 0, exp_perr = 0, exp_ovr = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    uart_rx_param #(
        .clk_freq       (50000000),
        .uart_baud_rate (1152000),
        .DATA_BITS      (8),
        .STOP_BITS      (1),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rxd   (uart_rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_count   (rx_count),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    // Count every cycle an error output is high; a stretched pulse shows up as extra counts.
    always @(posedge clk) begin
        if (!rst) begin
            if (frame_err)  n_ferr++;
            if (parity_err) n_perr++;
            if (overrun)    n_ovr++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        uart_rxd = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
`ifdef UART_RX_PARITY_EN
        send_bit(par_v);
`else
        if (par_v === 1'bx) $display("note: undefined parity argument");
`endif
        send_bit(stop_v);
        uart_rxd = 1'b1;
    endtask

    // Well-formed frame; model the FIFO acceptance or overrun.
    task automatic send_good(input logic [7:0] d);
        send_frame(d, 1'b1, ^d);
        if (sb.size() < DEPTH) sb.push_back(d);
        else exp_ovr++;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(rx_count), 32'(sb.size()));
        chk({tag, "_valid"}, 32'(rx_valid), 32'(sb.size() != 0));
        chk({tag, "_frame_err"}, n_ferr, exp_ferr);
        chk({tag, "_parity_err"}, n_perr, exp_perr);
        chk({tag, "_overrun"}, n_ovr, exp_ovr);
    endtask

    // Pops n words back to back, comparing each head against the scoreboard.
    task automatic drain(input int n);
        int left;
        int budget;
        left = n;
        budget = 200;
        while (left > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (rx_valid) begin
                rx_ready = 1'b1;
                if (sb.size() == 0) chk("drain_unexpected_word", 32'(rx_data), 32'hFFFF_FFFF);
                else chk("rx_data", 32'(rx_data), 32'(sb.pop_front()));
                left--;
            end else begin
                rx_ready = 1'b0;
            end
        end
        @(negedge clk);
        rx_ready = 1'b0;
        if (left > 0) chk("drain_timeout", left, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_count", 32'(rx_count), 0);
        chk("rst_data", 32'(rx_data), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_parity_err", 32'(parity_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        idle(10);

        send_good(8'hA5);
        idle(10);
        check_state("a5");
        drain(1);
        check_state("a5_pop");

        uart_rxd = 1'b0;
        repeat (6) @(negedge clk);
        uart_rxd = 1'b1;
        idle(60);
        check_state("glitch");

        send_frame(8'h3C, 1'b0, ^8'h3C);
        uart_rxd = 1'b0;
        idle(100);
        uart_rxd = 1'b1;
        exp_ferr++;
        idle(40);
        check_state("frame_err");
        send_good(8'h11);
        idle(10);
        check_state("after_break");
        drain(1);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        exp_perr++;
        idle(10);
        check_state("parity_bad");
        send_frame(8'h07, 1'b1, 1'b1);
        sb.push_back(8'h07);
        idle(10);
        check_state("parity_good");
        drain(1);
`endif

        for (int i = 1; i <= 5; i++) begin
            send_good(8'(i));
            idle(10);
        end
        check_state("overflow");
        drain(4);
        check_state("overflow_pop");

        send_good(8'h33);
        idle(10);
        check_state("pre_reset");
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        idle(5);
        rst = 1'b1;
        idle(4);
        sb.delete();
        uart_rxd = 1'b1;
        chk("mid_rst_count", 32'(rx_count), 0);
        rst = 1'b0;
        idle(40);
        check_state("post_reset");
        send_good(8'h5A);
        idle(10);
        check_state("after_reset_frame");
        drain(1);
        check_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
